vlt_mul_sched: RTL and testbench

- Shares one shift-add vbits datapath among the five VLT structure requesters: IQ, ROB, LQ, SQ and InstBuff.
- Replaces the per-structure multipliers in the VLT top.
- Round-robin arbitrates one request per cycle and computes saturated vbits in a 2-stage pipeline.
- Returns each tagged result and keeps per-structure saturating vbits accumulators and sample counters for SVF reporting.

---
 rtl/vlt_pkg.sv | 38 +++
 rtl/rr_arb5.sv | 39 +++
 rtl/vlt_mul_sched.sv | 145 ++++++++++++++
 tb/tb_vlt_mul_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vlt_pkg.sv
// Shared constants and request bundle for the VLT vbits scheduler.
// Requester indices, operand widths and the mod-5 wrap helper.
package vlt_pkg;

  localparam int NUM_REQ      = 5;
  localparam int REQ_IQ       = 0;
  localparam int REQ_ROB      = 1;
  localparam int REQ_LQ       = 2;
  localparam int REQ_SQ       = 3;
  localparam int REQ_INSTBUFF = 4;

  localparam int IDX_W   = 3;
  localparam int DUR_W   = 10;
  localparam int SHIFT_W = 4;
  localparam int PREV_W  = 12;
  localparam int VBITS_W = 18;
  localparam int SUM_W   = 25;

  localparam logic [VBITS_W-1:0] VBITS_MAX = 18'h3FFFF;

  typedef struct packed {
    logic [DUR_W-1:0]   dur;
    logic [SHIFT_W-1:0] shift1;
    logic               shift1_v;
    logic [SHIFT_W-1:0] shift2;
    logic               shift2_v;
    logic [PREV_W-1:0]  prev;
  } vlt_req_t;

  function automatic logic [IDX_W-1:0] wrap5(
    input logic [IDX_W:0] v
  );
    logic [IDX_W:0] t;
    t = (v >= 4'd5) ? v - 4'd5 : v;
    return t[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arb5.sv
// Five-way round-robin arbiter with a one-hot grant.
// The search starts at the pointer; the pointer moves past each winner.
module rr_arb5
  import vlt_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               gnt_v
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_id = '0;
    gnt_v  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap5({1'b0, ptr_q} + 4'(k));
      if (!gnt_v && req[idx]) begin
        gnt_v  = 1'b1;
        gnt_id = idx;
      end
    end
    // no grant may leak out while reset is held
    if (!rst_n) gnt_v = 1'b0;
    gnt   = gnt_v ? (NUM_REQ'(1) << gnt_id) : '0;
    ptr_d = gnt_v ? wrap5({1'b0, gnt_id} + 4'd1) : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vlt_mul_sched.sv
// Shared shift-add vbits engine for IQ/ROB/LQ/SQ/InstBuff.
// Two-stage pipeline with saturating per-requester accumulators.
module vlt_mul_sched
  import vlt_pkg::*;
#(
  parameter int                 ACC_W          = 24,
  parameter int                 CNT_W          = 16,
  parameter logic [NUM_REQ-1:0] ZERO_PREV_MASK = 5'b10000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_v,
  output logic [NUM_REQ-1:0]         req_rdy,
  input  logic [NUM_REQ*DUR_W-1:0]   req_dur,
  input  logic [NUM_REQ*SHIFT_W-1:0] req_shift1,
  input  logic [NUM_REQ-1:0]         req_shift1_v,
  input  logic [NUM_REQ*SHIFT_W-1:0] req_shift2,
  input  logic [NUM_REQ-1:0]         req_shift2_v,
  input  logic [NUM_REQ*PREV_W-1:0]  req_prev,
  input  logic                       acc_clear,
  output logic                       res_v,
  output logic [IDX_W-1:0]           res_id,
  output logic [VBITS_W-1:0]         res_vbits,
  output logic [NUM_REQ*ACC_W-1:0]   acc_total,
  output logic [NUM_REQ*CNT_W-1:0]   acc_count,
  output logic                       busy
);

  vlt_req_t         req_a [NUM_REQ];
  logic [IDX_W-1:0] gnt_id;
  logic             gnt_v;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i].dur      = req_dur[i*DUR_W +: DUR_W];
      req_a[i].shift1   = req_shift1[i*SHIFT_W +: SHIFT_W];
      req_a[i].shift1_v = req_shift1_v[i];
      req_a[i].shift2   = req_shift2[i*SHIFT_W +: SHIFT_W];
      req_a[i].shift2_v = req_shift2_v[i];
      req_a[i].prev     = req_prev[i*PREV_W +: PREV_W];
    end
  end

  rr_arb5 u_arb (
    .clk    (clock),
    .rst_n  (reset),
    .req    (req_v),
    .gnt    (req_rdy),
    .gnt_id (gnt_id),
    .gnt_v  (gnt_v)
  );

  vlt_req_t         s1_op_q, s1_op_d;
  logic             s1_v_q;
  logic [IDX_W-1:0] s1_id_q;

  always_comb begin
    s1_op_d = req_a[gnt_id];
    if (ZERO_PREV_MASK[gnt_id]) s1_op_d.prev = '0;
  end

  logic [SUM_W-1:0]   p1, p2, sum;
  logic [VBITS_W-1:0] vb_d;

  always_comb begin
    p1   = s1_op_q.shift1_v ? (SUM_W'(s1_op_q.dur) << s1_op_q.shift1) : '0;
    p2   = s1_op_q.shift2_v ? (SUM_W'(s1_op_q.dur) << s1_op_q.shift2) : '0;
    sum  = p1 + p2 + SUM_W'(s1_op_q.prev);
    vb_d = (sum > SUM_W'(VBITS_MAX)) ? VBITS_MAX : sum[VBITS_W-1:0];
  end

  logic               res_v_q;
  logic [IDX_W-1:0]   res_id_q;
  logic [VBITS_W-1:0] res_vb_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_v_q   <= 1'b0;
      s1_id_q  <= '0;
      s1_op_q  <= '0;
      res_v_q  <= 1'b0;
      res_id_q <= '0;
      res_vb_q <= '0;
    end else begin
      s1_v_q   <= gnt_v;
      if (gnt_v) begin
        s1_id_q <= gnt_id;
        s1_op_q <= s1_op_d;
      end
      res_v_q  <= s1_v_q;
      res_id_q <= s1_v_q ? s1_id_q : '0;
      res_vb_q <= s1_v_q ? vb_d : '0;
    end
  end

  assign res_v     = res_v_q;
  assign res_id    = res_id_q;
  assign res_vbits = res_vb_q;
  assign busy      = s1_v_q | res_v_q;

  logic [ACC_W-1:0] acc_q [NUM_REQ];
  logic [ACC_W-1:0] acc_d [NUM_REQ];
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];
  logic [ACC_W:0]   acc_s [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      acc_s[i] = {1'b0, acc_q[i]} + (ACC_W+1)'(res_vb_q);
      acc_d[i] = acc_q[i];
      cnt_d[i] = cnt_q[i];
      if (acc_clear) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end else if (res_v_q && res_id_q == IDX_W'(i)) begin
        acc_d[i] = acc_s[i][ACC_W] ? '1 : acc_s[i][ACC_W-1:0];
        cnt_d[i] = (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        acc_q[i] <= acc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    acc_total = '0;
    acc_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      acc_total[i*ACC_W +: ACC_W] = acc_q[i];
      acc_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_vlt_mul_sched.sv
// Scoreboard bench for vlt_mul_sched: directed requests in,
// a monitor pops expected results and checks id, vbits and arrival cycle.
module tb_vlt_mul_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  req_v = '0;
  logic [4:0]  req_rdy;
  logic [49:0] req_dur = '0;
  logic [19:0] req_shift1 = '0;
  logic [4:0]  req_shift1_v = '0;
  logic [19:0] req_shift2 = '0;
  logic [4:0]  req_shift2_v = '0;
  logic [59:0] req_prev = '0;
  logic        acc_clear = 1'b0;
  logic        res_v;
  logic [2:0]  res_id;
  logic [17:0] res_vbits;
  logic [119:0] acc_total;
  logic [79:0]  acc_count;
  logic        busy;

  vlt_mul_sched dut (
    .clock        (clock),
    .reset        (reset),
    .req_v        (req_v),
    .req_rdy      (req_rdy),
    .req_dur      (req_dur),
    .req_shift1   (req_shift1),
    .req_shift1_v (req_shift1_v),
    .req_shift2   (req_shift2),
    .req_shift2_v (req_shift2_v),
    .req_prev     (req_prev),
    .acc_clear    (acc_clear),
    .res_v        (res_v),
    .res_id       (res_id),
    .res_vbits    (res_vbits),
    .acc_total    (acc_total),
    .acc_count    (acc_count),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int id;
    int vb;
    int cy;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] acc_of(int i);
    return acc_total[i*24 +: 24];
  endfunction

  function automatic logic [15:0] cnt_of(int i);
    return acc_count[i*16 +: 16];
  endfunction

  task automatic set_op(int id, int dur, int s1, int s1v,
                        int s2, int s2v, int prev);
    req_dur[id*10 +: 10]   = 10'(dur);
    req_shift1[id*4 +: 4]  = 4'(s1);
    req_shift1_v[id]       = 1'(s1v);
    req_shift2[id*4 +: 4]  = 4'(s2);
    req_shift2_v[id]       = 1'(s2v);
    req_prev[id*12 +: 12]  = 12'(prev);
  endtask

  task automatic issue(int id, int dur, int s1, int s1v,
                       int s2, int s2v, int prev, int exp);
    @(negedge clock);
    set_op(id, dur, s1, s1v, s2, s2v, prev);
    req_v = 5'(1 << id);
    #1;
    chk("grant", 64'(req_rdy), 64'(1 << id));
    sbq.push_back('{id, exp, cyc + 2});
    @(posedge clock);
    #1 req_v = '0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clock);
  endtask

  // monitor: every presented result must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (res_v) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_res: got id %0d vbits %0h expected none",
                   res_id, res_vbits);
        end else begin
          e = sbq.pop_front();
          chk("res_id", 64'(res_id), 64'(e.id));
          chk("res_vbits", 64'(res_vbits), 64'(e.vb));
          chk("res_cycle", 64'(cyc), 64'(e.cy));
        end
      end
    end
  end

  initial begin
    int k;
    // reset state, with requests pending to prove grants are gated
    req_v = '1;
    idle(2);
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    chk("rst_res_v", 64'(res_v), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_acc", 64'(acc_total[63:0]), 64'd0);
    chk("rst_cnt", 64'(acc_count[63:0]), 64'd0);
    req_v = '0;
    @(negedge clock) reset = 1'b1;

    // IQ: 10<<2 + 10<<0 + 5 = 55
    issue(0, 10, 2, 1, 0, 1, 5, 55);
    idle(4);
    chk("iq_acc", 64'(acc_of(0)), 64'd55);
    chk("iq_cnt", 64'(cnt_of(0)), 64'd1);

    // ROB saturating vbits, accumulator approaches then pins at all-ones
    for (int i = 0; i < 64; i++) issue(1, 1023, 15, 1, 0, 0, 0, 'h3FFFF);
    idle(4);
    chk("rob_acc64", 64'(acc_of(1)), 64'hFFFFC0);
    chk("rob_cnt64", 64'(cnt_of(1)), 64'd64);
    issue(1, 1023, 15, 1, 0, 0, 0, 'h3FFFF);
    issue(1, 1023, 15, 1, 0, 0, 0, 'h3FFFF);
    idle(4);
    chk("rob_acc_sat", 64'(acc_of(1)), 64'hFFFFFF);
    chk("rob_cnt66", 64'(cnt_of(1)), 64'd66);

    // InstBuff prev forced to zero: 3<<1 = 6
    issue(4, 3, 1, 1, 0, 0, 100, 6);
    idle(4);
    chk("ib_acc", 64'(acc_of(4)), 64'd6);

    // round robin, pointer now 0; vbits per id: 8,11,19,39,80
    for (int i = 0; i < 5; i++) set_op(i, i + 1, i, 1, 0, 0, 7);
    for (k = 0; k < 10; k++) begin
      @(negedge clock);
      req_v = '1;
      #1;
      chk("rr_grant", 64'(req_rdy), 64'(1 << (k % 5)));
      case (k % 5)
        0: sbq.push_back('{0, 8, cyc + 2});
        1: sbq.push_back('{1, 11, cyc + 2});
        2: sbq.push_back('{2, 19, cyc + 2});
        3: sbq.push_back('{3, 39, cyc + 2});
        default: sbq.push_back('{4, 80, cyc + 2});
      endcase
    end
    @(posedge clock);
    #1 req_v = '0;
    idle(4);
    chk("rr_acc0", 64'(acc_of(0)), 64'd71);
    chk("rr_cnt0", 64'(cnt_of(0)), 64'd3);
    chk("rr_acc4", 64'(acc_of(4)), 64'd166);
    chk("rr_cnt1", 64'(cnt_of(1)), 64'd68);

    // plain clear
    @(negedge clock) acc_clear = 1'b1;
    @(posedge clock);
    #1 acc_clear = 1'b0;
    @(negedge clock);
    chk("clr_acc1", 64'(acc_of(1)), 64'd0);
    chk("clr_cnt0", 64'(cnt_of(0)), 64'd0);

    // clear colliding with a valid SQ result
    issue(3, 5, 3, 1, 0, 0, 0, 40);
    idle(4);
    chk("sq_acc40", 64'(acc_of(3)), 64'd40);
    issue(3, 5, 2, 1, 0, 0, 0, 20);
    @(negedge clock);
    @(negedge clock);
    acc_clear = 1'b1;
    chk("coll_res_v", 64'(res_v), 64'd1);
    @(posedge clock);
    #1 acc_clear = 1'b0;
    @(negedge clock);
    chk("coll_acc3", 64'(acc_of(3)), 64'd0);
    chk("coll_cnt3", 64'(cnt_of(3)), 64'd0);

    // reset while an LQ result is in flight
    issue(2, 1, 0, 1, 0, 0, 0, 1);
    reset = 1'b0;
    sbq.delete();
    req_v = '1;
    @(negedge clock);
    chk("mrst_res_v", 64'(res_v), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_rdy", 64'(req_rdy), 64'd0);
    chk("mrst_vbits", 64'(res_vbits), 64'd0);
    req_v = '0;
    @(negedge clock) reset = 1'b1;
    idle(3);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // pointer back at 0: ROB wins over LQ; 2 + 2 + 1 = 5
    @(negedge clock);
    set_op(1, 2, 0, 1, 0, 1, 1);
    set_op(2, 9, 1, 1, 0, 0, 3);
    req_v = 5'b00110;
    #1;
    chk("post_rst_grant", 64'(req_rdy), 64'b00010);
    sbq.push_back('{1, 5, cyc + 2});
    @(posedge clock);
    #1 req_v = '0;

    for (int w = 0; w < 20 && sbq.size() != 0; w++) @(negedge clock);
    idle(2);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    chk("final_cnt1", 64'(cnt_of(1)), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
